// File: rtl/ps2_pkg.sv
// PS/2 host transmitter shared definitions: FSM state encoding, common
// keyboard command bytes, frame length and the odd-parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_DATA,
    ST_ACK,
    ST_FINISH
  } ps2TxState_t;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;

  // start + 8 data + parity + stop
  localparam int PS2_FRAME_BITS = 11;

  // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
  function automatic logic oddParity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for one raw PS/2 pin plus falling-edge detect.
// Shared by the host transmit path and the scan-code receive path.
module ps2_line_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_fall
);

  logic meta;
  logic prev;

  // Shift the pin through two metastability stages and keep one cycle of history.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: reset to the idle-high line level so leaving reset never fakes a falling edge.
      meta    <= 1'b1;
      o_level <= 1'b1;
      prev    <= 1'b1;
    end else begin
      // NOTE: non-blocking so all three stages shift together on the same edge.
      meta    <= i_pin;
      o_level <= meta;
      prev    <= o_level;
    end
  end

  assign o_fall = prev & ~o_level;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Sends one command byte to the keyboard by
// inhibiting the clock, issuing request-to-send, then shifting data, odd
// parity and stop on device-generated clock falls and sampling the ack.
// Line outputs are open-drain low-enables (1 = pull low).
// Optional watchdog: define PS2_TX_TIMEOUT_EN to abort a transfer whose
// device clock stalls for TIMEOUT_US; otherwise only i_rst recovers a stall.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned INHIBIT_US  = 100
`ifdef PS2_TX_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_US  = 15_000
`endif
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_txData,
  input  logic       i_txStart,
  input  logic       i_ps2Clk,
  input  logic       i_ps2Data,
  output logic       o_ps2ClkOe,
  output logic       o_ps2DataOe,
  output logic       o_txBusy,
  output logic       o_txDone,
  output logic       o_txErr
);

  localparam int unsigned INHIBIT_CYC = CLK_FREQ_HZ / 1_000_000 * INHIBIT_US;
  localparam int unsigned INH_W       = $clog2(INHIBIT_CYC);
  // Start bit goes out one cycle before the clock is released.
  localparam logic [INH_W-1:0] INH_START = INH_W'(INHIBIT_CYC - 2);
  localparam logic [INH_W-1:0] INH_LAST  = INH_W'(INHIBIT_CYC - 1);
  localparam logic [3:0]       PAR_BIT   = 4'(PS2_FRAME_BITS - 3);
  localparam logic [3:0]       STOP_BIT  = 4'(PS2_FRAME_BITS - 2);

`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned TIMEOUT_CYC = TIMEOUT_US * (CLK_FREQ_HZ / 1_000_000);
  localparam int unsigned TO_W        = $clog2(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] wdCnt;
`endif

  ps2TxState_t      state;
  logic [7:0]       txByte;
  logic             parity;
  logic [INH_W-1:0] inhCnt;
  logic [3:0]       bitCnt;
  logic             nack;

  logic clkLvl, clkFall;
  logic dataLvl, unusedDataFall;

  ps2_line_sync uClkSync (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_pin  (i_ps2Clk),
    .o_level(clkLvl),
    .o_fall (clkFall)
  );

  ps2_line_sync uDataSync (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_pin  (i_ps2Data),
    .o_level(dataLvl),
    .o_fall (unusedDataFall)
  );

  // Transfer sequencer with registered line enables and status outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      txByte      <= '0;
      parity      <= 1'b0;
      inhCnt      <= '0;
      bitCnt      <= '0;
      nack        <= 1'b0;
      o_ps2ClkOe  <= 1'b0;
      o_ps2DataOe <= 1'b0;
      o_txBusy    <= 1'b0;
      o_txDone    <= 1'b0;
      o_txErr     <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      wdCnt       <= '0;
`endif
    end else begin
      o_txDone <= 1'b0;
      o_txErr  <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (i_txStart) begin
            txByte     <= i_txData;
            parity     <= oddParity(i_txData);
            inhCnt     <= '0;
            o_txBusy   <= 1'b1;
            o_ps2ClkOe <= 1'b1;
            state      <= ST_INHIBIT;
          end
        end

        ST_INHIBIT: begin
          inhCnt <= inhCnt + 1'b1;
          if (inhCnt == INH_START) o_ps2DataOe <= 1'b1;
          if (inhCnt == INH_LAST) begin
            o_ps2ClkOe <= 1'b0;
            state      <= ST_REQ;
          end
        end

        // Our own clock pull-down takes two cycles to clear the synchroniser.
        ST_REQ: begin
          if (clkLvl) begin
            bitCnt <= '0;
            state  <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (clkFall) begin
            if (bitCnt < PAR_BIT) begin
              o_ps2DataOe <= ~txByte[bitCnt[2:0]];
            end else if (bitCnt == PAR_BIT) begin
              o_ps2DataOe <= ~parity;
            end else begin
              o_ps2DataOe <= 1'b0;
            end
            bitCnt <= bitCnt + 1'b1;
            if (bitCnt == STOP_BIT) state <= ST_ACK;
          end
        end

        ST_ACK: begin
          if (clkFall) begin
            nack  <= dataLvl;
            state <= ST_FINISH;
          end
        end

        ST_FINISH: begin
          if (clkLvl && dataLvl) begin
            o_txDone <= 1'b1;
            o_txErr  <= nack;
            o_txBusy <= 1'b0;
            state    <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase

`ifdef PS2_TX_TIMEOUT_EN
      // Watchdog restarts on each device clock fall and overrides the sequencer on expiry.
      if (state inside {ST_REQ, ST_DATA, ST_ACK, ST_FINISH}) begin
        if (wdCnt == TO_LAST) begin
          wdCnt       <= '0;
          o_ps2ClkOe  <= 1'b0;
          o_ps2DataOe <= 1'b0;
          o_txDone    <= 1'b1;
          o_txErr     <= 1'b1;
          o_txBusy    <= 1'b0;
          state       <= ST_IDLE;
        end else if (clkFall) begin
          wdCnt <= '0;
        end else begin
          wdCnt <= wdCnt + 1'b1;
        end
      end else begin
        wdCnt <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a PS/2 device model on wired-AND
// lines, a per-cycle transaction-level model of the host outputs, and
// directed transfers with hand-computed frame values.
module tb_ps2_host_tx;

  localparam int INHIBIT_CYC = 10_000;
  localparam int HALF        = 20;      // device clock half period in system cycles
`ifdef PS2_TX_TIMEOUT_EN
  localparam int TIMEOUT_CYC = 2_000;
`endif

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [7:0] i_txData;
  logic       i_txStart;
  logic       o_ps2ClkOe, o_ps2DataOe, o_txBusy, o_txDone, o_txErr;

  logic devClkLow, devDataLow;
  wire  ps2ClkPin  = ~o_ps2ClkOe & ~devClkLow;
  wire  ps2DataPin = ~o_ps2DataOe & ~devDataLow;

  ps2_host_tx #(
    .CLK_FREQ_HZ(100_000_000),
    .INHIBIT_US (100)
`ifdef PS2_TX_TIMEOUT_EN
    ,
    .TIMEOUT_US (20)
`endif
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_txData   (i_txData),
    .i_txStart  (i_txStart),
    .i_ps2Clk   (ps2ClkPin),
    .i_ps2Data  (ps2DataPin),
    .o_ps2ClkOe (o_ps2ClkOe),
    .o_ps2DataOe(o_ps2DataOe),
    .o_txBusy   (o_txBusy),
    .o_txDone   (o_txDone),
    .o_txErr    (o_txErr)
  );

  always #5 i_clk = ~i_clk;

  int nVec  = 0;
  int nFail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic waitCyc(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // ---------------- transaction model + per-cycle compare ----------------
  bit prevRst   = 1'b1;
  bit prevStart = 1'b0;
  bit mBusy     = 1'b0;
  int inhLeft   = 0;
  bit expNack   = 1'b0;
  bit timeoutExp = 1'b0;
  bit devDone   = 1'b0;
  int doneCnt   = 0;
  bit lastErr   = 1'b0;
  int runLen    = 0;
  int lastRun   = 0;

  always @(negedge i_clk) begin
    // Inputs seen at the previous rising edge decide the model state now.
    if (prevRst) begin
      mBusy   = 1'b0;
      inhLeft = 0;
    end else if (prevStart && !mBusy) begin
      mBusy   = 1'b1;
      inhLeft = INHIBIT_CYC;
    end else if (inhLeft > 0) begin
      inhLeft--;
    end

    if (o_ps2ClkOe === 1'b1) runLen++;
    else if (runLen != 0) begin
      lastRun = runLen;
      runLen  = 0;
    end

    if (prevRst) begin
      check("reset_outputs", {o_ps2ClkOe, o_ps2DataOe, o_txBusy, o_txDone, o_txErr}, 5'b0);
    end else if (inhLeft > 0) begin
      check("inhibit_outputs", {o_ps2ClkOe, o_ps2DataOe, o_txBusy, o_txDone, o_txErr},
            {1'b1, inhLeft == 1, 1'b1, 1'b0, 1'b0});
    end else if (mBusy) begin
      check("active_clk_released", o_ps2ClkOe, 1'b0);
      if (o_txDone === 1'b1) begin
        check("done_cycle", {o_txBusy, o_txErr, o_ps2DataOe}, {1'b0, expNack, 1'b0});
        check("done_after_frame", devDone || timeoutExp, 1'b1);
        doneCnt++;
        lastErr = o_txErr;
        mBusy   = 1'b0;
      end else begin
        check("active_busy", {o_txBusy, o_txErr}, 2'b10);
      end
    end else begin
      check("idle_outputs", {o_ps2ClkOe, o_ps2DataOe, o_txBusy, o_txDone, o_txErr}, 5'b0);
    end

    prevRst   = i_rst;
    prevStart = i_txStart;
  end

  // ---------------- PS/2 device model ----------------
  int devBits = 0;

  // Waits for request-to-send, clocks 10 bits sampling on rising edges, then the ack slot.
  task automatic deviceFrame(input bit ack, output logic [10:0] frame, output bit ok);
    int t;
    frame   = '0;
    devBits = 0;
    t = 0;
    while (!(ps2ClkPin && !ps2DataPin) && t < INHIBIT_CYC + 500) begin
      waitCyc(1);
      t++;
    end
    ok = (ps2ClkPin && !ps2DataPin);
    if (!ok) return;
    frame[0] = ps2DataPin;
    waitCyc(HALF);
    for (int i = 1; i < 11; i++) begin
      devClkLow = 1'b1;
      waitCyc(HALF);
      devClkLow = 1'b0;
      frame[i]  = ps2DataPin;
      devBits++;
      waitCyc(HALF);
    end
    if (ack) devDataLow = 1'b1;
    waitCyc(HALF / 2);
    devClkLow = 1'b1;
    waitCyc(HALF);
    devDone    = 1'b1;
    devClkLow  = 1'b0;
    devDataLow = 1'b0;
    waitCyc(HALF / 2);
  endtask

  task automatic startTx(input logic [7:0] b);
    devDone   = 1'b0;
    i_txData  = b;
    i_txStart = 1'b1;
    waitCyc(1);
    i_txStart = 1'b0;
  endtask

  // One full transfer against the device model; checks the captured frame.
  task automatic xfer(input logic [7:0] b, input bit ack, output logic [10:0] frame);
    int d0;
    int t;
    bit ok;
    expNack = !ack;
    d0 = doneCnt;
    startTx(b);
    deviceFrame(ack, frame, ok);
    check("device_saw_rts", ok, 1'b1);
    t = 0;
    while (doneCnt == d0 && t < 200) begin
      waitCyc(1);
      t++;
    end
    waitCyc(10);
    check("done_count", doneCnt - d0, 1);
    check("frame_start", frame[0], 1'b0);
    check("frame_data", frame[8:1], b);
    check("frame_parity", frame[9], ($countones(b) % 2) == 0);
    check("frame_stop", frame[10], 1'b1);
  endtask

  logic [10:0] fr;
  bit          okR;
  int          d0;
  int          t;

  initial begin
    i_rst      = 1'b1;
    i_txData   = 8'h00;
    i_txStart  = 1'b0;
    devClkLow  = 1'b0;
    devDataLow = 1'b0;
    waitCyc(4);
    check("reset_state", {o_ps2ClkOe, o_ps2DataOe, o_txBusy, o_txDone, o_txErr}, 5'b0);
    i_rst = 1'b0;
    waitCyc(3);

    // Reset in the middle of the data phase releases both lines on the next edge.
    expNack = 1'b0;
    startTx(8'hA5);
    fork
      deviceFrame(1'b1, fr, okR);
      begin
        t = 0;
        while (devBits < 3 && t < 20_000) begin
          waitCyc(1);
          t++;
        end
        check("rst_reached_data", devBits >= 3, 1'b1);
        check("rst_busy_before", o_txBusy, 1'b1);
        i_rst = 1'b1;
        waitCyc(1);
        check("rst_mid_data", {o_ps2ClkOe, o_ps2DataOe, o_txBusy}, 3'b000);
        waitCyc(1);
        i_rst = 1'b0;
      end
    join
    waitCyc(20);

    // Set-LED command with ack: exact inhibit length and literal frame.
    xfer(8'hED, 1'b1, fr);
    check("ed_inhibit_len", lastRun, 10_000);
    check("ed_frame_literal", fr, 11'h7DA);
    check("ed_no_err", lastErr, 1'b0);

    // Parity boundaries.
    xfer(8'h01, 1'b1, fr);
    check("p01_parity_literal", fr[9], 1'b0);
    check("p01_no_err", lastErr, 1'b0);
    xfer(8'hFF, 1'b1, fr);
    check("pff_parity_literal", fr[9], 1'b1);
    check("pff_no_err", lastErr, 1'b0);

    // Device leaves data high in the ack slot.
    xfer(8'hED, 1'b0, fr);
    check("nack_err", lastErr, 1'b1);

    // Start pulse while busy is ignored and the byte in flight is unaffected.
    d0 = doneCnt;
    fork
      xfer(8'hF4, 1'b1, fr);
      begin
        waitCyc(300);
        i_txData  = 8'h00;
        i_txStart = 1'b1;
        waitCyc(1);
        i_txStart = 1'b0;
      end
    join
    waitCyc(50);
    check("f4_frame_literal", fr, 11'h5E8);
    check("f4_single_done", doneCnt - d0, 1);
    check("f4_idle_after", o_txBusy, 1'b0);

    // Device never clocks.
    d0 = doneCnt;
`ifdef PS2_TX_TIMEOUT_EN
    expNack    = 1'b1;
    timeoutExp = 1'b1;
    startTx(8'h55);
    t = 0;
    while (doneCnt == d0 && t < INHIBIT_CYC + TIMEOUT_CYC + 200) begin
      waitCyc(1);
      t++;
    end
    check("timeout_done", doneCnt - d0, 1);
    check("timeout_not_early", t >= INHIBIT_CYC + TIMEOUT_CYC, 1'b1);
    check("timeout_not_late", t <= INHIBIT_CYC + TIMEOUT_CYC + 10, 1'b1);
    check("timeout_err", lastErr, 1'b1);
    check("timeout_released", {o_ps2ClkOe, o_ps2DataOe, o_txBusy}, 3'b000);
    timeoutExp = 1'b0;
`else
    startTx(8'h55);
    waitCyc(INHIBIT_CYC + 3000);
    check("stall_busy", o_txBusy, 1'b1);
    check("stall_no_done", doneCnt - d0, 0);
    i_rst = 1'b1;
    waitCyc(2);
    i_rst = 1'b0;
    waitCyc(2);
    check("stall_reset_idle", {o_ps2ClkOe, o_ps2DataOe, o_txBusy}, 3'b000);
`endif

    waitCyc(5);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

  initial begin
    #(95_000 * 10);
    $display("FAIL global_timeout: simulation did not reach the end");
    $fatal(1);
  end

endmodule
